misc_drive_reader: RTL and testbench

Sequential driver and checker for the combinational `Misc` operand/result interface. It accepts operand requests on a valid/ready stream and drives registered `A`/`B`/`C` into the device under test. After a programmable settle time it samples `XOUT` and compares it with the expected self-check value `((A - B) + C) + 4`. It returns the sampled result and a mismatch flag on a valid/ready response stream, and keeps a saturating error count. It sits in the test harness opposite the `Misc` combinational block, as its reader.

---
 rtl/misc_drive_reader.sv | 125 ++++++++++++
 tb/tb_misc_drive_reader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/misc_drive_reader.sv
// Drives registered A/B/C operands into the combinational Misc block, samples XOUT
// after a programmable settle time, and reports the result plus a self-check flag.
module misc_drive_reader #(
    parameter int NX     = 8,
    parameter int NB     = 4,
    parameter int SETTLE = 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic [NX-1:0] REQ_A,
    input  logic [NB-1:0] REQ_B,
    input  logic [NX-1:0] REQ_C,
    output logic [NX-1:0] A,
    output logic [NB-1:0] B,
    output logic [NX-1:0] C,
    input  logic [NX-1:0] XOUT,
    output logic          RSP_VALID,
    input  logic          RSP_READY,
    output logic [NX-1:0] RSP_DATA,
    output logic          RSP_MISMATCH,
    input  logic          ERR_CLR,
    output logic [7:0]    ERR_COUNT
);

    generate
        if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
            $error("misc_drive_reader: SETTLE must lie in 1..15");
        end
        if (NB > NX) begin : g_bad_nb
            $error("misc_drive_reader: NB must not exceed NX");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [3:0]    settle_cnt;
    logic [NX-1:0] expected;
    logic          accept;
    logic          capture;
    logic          mismatch_now;

    // Self-check value: every term zero-extended to NX bits, wrap-around is normal.
    function automatic logic [NX-1:0] calc_expected(input logic [NX-1:0] a,
                                                    input logic [NB-1:0] b,
                                                    input logic [NX-1:0] c);
        return a - NX'(b) + c + NX'(4);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign REQ_READY    = (state == IDLE);
    assign RSP_VALID    = (state == RESP);
    assign accept       = REQ_VALID && (state == IDLE);
    assign capture      = (state == WAIT) && (settle_cnt == 4'd1);
    assign expected     = calc_expected(A, B, C);
    // 4-state compare so X/Z on XOUT is flagged in simulation.
    assign mismatch_now = (XOUT !== expected);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (REQ_VALID)  state_nxt = WAIT;
            WAIT:    if (capture)    state_nxt = RESP;
            RESP:    if (RSP_READY)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            settle_cnt <= 4'd0;
            ERR_COUNT  <= 8'd0;
        end else begin
            if (accept) begin
                settle_cnt <= 4'(SETTLE);
            end else if (state == WAIT) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            // A clear coinciding with a mismatch capture leaves exactly that one counted.
            if (ERR_CLR) begin
                ERR_COUNT <= (capture && mismatch_now) ? 8'd1 : 8'd0;
            end else if (capture && mismatch_now) begin
                ERR_COUNT <= sat_inc(ERR_COUNT);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            A            <= '0;
            B            <= '0;
            C            <= '0;
            RSP_DATA     <= '0;
            RSP_MISMATCH <= 1'b0;
        end else begin
            if (accept) begin
                A <= REQ_A;
                B <= REQ_B;
                C <= REQ_C;
            end
            if (capture) begin
                RSP_DATA     <= XOUT;
                RSP_MISMATCH <= mismatch_now;
            end
        end
    end

endmodule

// File: tb/tb_misc_drive_reader.sv
// Bench for misc_drive_reader: one instance with SETTLE=1 and one with SETTLE=3,
// directed cases plus randomized transactions against a transaction-level model.
module tb_misc_drive_reader;

    localparam int S0 = 1;
    localparam int S1 = 3;

    logic       clk = 1'b0;
    logic [1:0] rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic [1:0] rsp_mismatch;
    logic [1:0] err_clr;
    logic [7:0] req_a    [2];
    logic [3:0] req_b    [2];
    logic [7:0] req_c    [2];
    logic [7:0] a_o      [2];
    logic [3:0] b_o      [2];
    logic [7:0] c_o      [2];
    logic [7:0] xout     [2];
    logic [7:0] rsp_data [2];
    logic [7:0] err_count[2];

    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] m_err   [2];
    logic [7:0] cur_a   [2];
    logic [3:0] cur_b   [2];
    logic [7:0] cur_c   [2];
    logic [7:0] exp_data[2];
    logic       exp_mis [2];

    always #5 clk = ~clk;

    misc_drive_reader #(.NX(8), .NB(4), .SETTLE(S0)) u_dut0 (
        .CLK(clk), .RST_N(rst_n[0]), .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]),
        .REQ_A(req_a[0]), .REQ_B(req_b[0]), .REQ_C(req_c[0]),
        .A(a_o[0]), .B(b_o[0]), .C(c_o[0]), .XOUT(xout[0]),
        .RSP_VALID(rsp_valid[0]), .RSP_READY(rsp_ready[0]), .RSP_DATA(rsp_data[0]),
        .RSP_MISMATCH(rsp_mismatch[0]), .ERR_CLR(err_clr[0]), .ERR_COUNT(err_count[0])
    );

    misc_drive_reader #(.NX(8), .NB(4), .SETTLE(S1)) u_dut1 (
        .CLK(clk), .RST_N(rst_n[1]), .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]),
        .REQ_A(req_a[1]), .REQ_B(req_b[1]), .REQ_C(req_c[1]),
        .A(a_o[1]), .B(b_o[1]), .C(c_o[1]), .XOUT(xout[1]),
        .RSP_VALID(rsp_valid[1]), .RSP_READY(rsp_ready[1]), .RSP_DATA(rsp_data[1]),
        .RSP_MISMATCH(rsp_mismatch[1]), .ERR_CLR(err_clr[1]), .ERR_COUNT(err_count[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // (A - B + C + 4) reduced modulo 256 with plain integer arithmetic.
    function automatic logic [7:0] ref_exp(input logic [7:0] a, input logic [3:0] b,
                                           input logic [7:0] c);
        int s;
        s = int'(a) - int'(b) + int'(c) + 4;
        s = ((s % 256) + 256) % 256;
        return 8'(s);
    endfunction

    task automatic issue(input int d, input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] c);
        int w = 0;
        while (!req_ready[d] && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready_timeout", 32'(w < 50), 32'd1);
        req_a[d] = a;
        req_b[d] = b;
        req_c[d] = c;
        req_valid[d] = 1'b1;
        @(negedge clk);
        req_valid[d] = 1'b0;
        cur_a[d] = a;
        cur_b[d] = b;
        cur_c[d] = c;
        chk("A_reg", a_o[d], a);
        chk("B_reg", b_o[d], b);
        chk("C_reg", c_o[d], c);
        chk("req_ready_busy", req_ready[d], 1'b0);
    endtask

    // xearly is on XOUT until just before the sampling edge, then xval replaces it.
    task automatic await_rsp(input int d, input logic [7:0] xearly, input logic [7:0] xval,
                             input bit clr);
        int         s;
        int         lat;
        logic [7:0] e;
        logic       mis;
        s   = (d == 0) ? S0 : S1;
        lat = 0;
        e   = ref_exp(cur_a[d], cur_b[d], cur_c[d]);
        xout[d] = xearly;
        for (int i = 1; i <= 20; i++) begin
            if (i == s) begin
                xout[d] = xval;
                if (clr) err_clr[d] = 1'b1;
            end
            @(negedge clk);
            err_clr[d] = 1'b0;
            if (rsp_valid[d]) begin
                lat = i;
                break;
            end
        end
        chk("latency", lat, s);
        mis = (xval !== e);
        if (clr) m_err[d] = mis ? 8'd1 : 8'd0;
        else if (mis && m_err[d] != 8'd255) m_err[d] = m_err[d] + 8'd1;
        exp_data[d] = xval;
        exp_mis[d]  = mis;
        chk("rsp_data", rsp_data[d], xval);
        chk("rsp_mismatch", rsp_mismatch[d], mis);
        chk("err_count", err_count[d], m_err[d]);
    endtask

    task automatic handshake(input int d, input int bp);
        for (int i = 0; i < bp; i++) begin
            chk("hold_valid", rsp_valid[d], 1'b1);
            chk("hold_data", rsp_data[d], exp_data[d]);
            chk("hold_req_ready", req_ready[d], 1'b0);
            @(negedge clk);
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk("post_valid", rsp_valid[d], 1'b0);
        chk("post_req_ready", req_ready[d], 1'b1);
        chk("post_data", rsp_data[d], exp_data[d]);
        chk("post_mismatch", rsp_mismatch[d], exp_mis[d]);
    endtask

    task automatic do_txn(input int d, input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] c, input logic [7:0] xval, input int bp,
                          input bit clr);
        issue(d, a, b, c);
        await_rsp(d, xval ^ 8'h5A, xval, clr);
        handshake(d, bp);
    endtask

    task automatic check_reset_vals(input int d);
        chk("rst_A", a_o[d], 8'h00);
        chk("rst_B", b_o[d], 4'h0);
        chk("rst_C", c_o[d], 8'h00);
        chk("rst_rsp_data", rsp_data[d], 8'h00);
        chk("rst_rsp_mismatch", rsp_mismatch[d], 1'b0);
        chk("rst_err_count", err_count[d], 8'h00);
        chk("rst_rsp_valid", rsp_valid[d], 1'b0);
        chk("rst_req_ready", req_ready[d], 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra, rc, e, xv;
        logic [3:0] rb;
        rst_n     = 2'b00;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        err_clr   = 2'b00;
        for (int d = 0; d < 2; d++) begin
            req_a[d] = 8'h00; req_b[d] = 4'h0; req_c[d] = 8'h00;
            xout[d]  = 8'h00; m_err[d] = 8'h00;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) check_reset_vals(d);
        rst_n = 2'b11;
        @(negedge clk);

        // Basic pass and wrap-around on the SETTLE=1 instance
        do_txn(0, 8'h10, 4'h3, 8'h20, 8'h31, 0, 1'b0);
        do_txn(0, 8'h02, 4'hF, 8'h00, 8'hF7, 0, 1'b0);
        do_txn(0, 8'hFF, 4'h0, 8'hFF, 8'h02, 1, 1'b0);

        // Mismatch, X on XOUT, then clear coinciding with a mismatch capture
        do_txn(0, 8'h10, 4'h3, 8'h20, 8'h30, 0, 1'b0);
        do_txn(0, 8'h20, 4'h3, 8'h20, 8'b0011000x, 0, 1'b0);
        chk("err_two", err_count[0], 8'd2);
        do_txn(0, 8'h10, 4'h3, 8'h20, 8'h00, 0, 1'b1);
        chk("err_clr_with_capture", err_count[0], 8'd1);

        // Backpressure on SETTLE=3 with an early XOUT value that must not be captured
        issue(1, 8'h40, 4'h5, 8'h01);
        await_rsp(1, 8'hAA, 8'h40, 1'b0);
        req_a[1] = 8'h11; req_b[1] = 4'h2; req_c[1] = 8'h03;
        req_valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", rsp_valid[1], 1'b1);
            chk("bp_data", rsp_data[1], 8'h40);
            chk("bp_req_ready", req_ready[1], 1'b0);
            chk("bp_A_held", a_o[1], 8'h40);
            @(negedge clk);
        end
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        rsp_ready[1] = 1'b0;
        chk("bp_post_valid", rsp_valid[1], 1'b0);
        chk("bp_post_req_ready", req_ready[1], 1'b1);
        chk("bp_not_yet_accepted", a_o[1], 8'h40);
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("bp_second_accepted", a_o[1], 8'h11);
        chk("bp_second_busy", req_ready[1], 1'b0);
        cur_a[1] = 8'h11; cur_b[1] = 4'h2; cur_c[1] = 8'h03;
        await_rsp(1, 8'h00, ref_exp(8'h11, 4'h2, 8'h03) ^ 8'h01, 1'b0);
        handshake(1, 0);

        // Reset pulse during WAIT discards the pending response
        issue(1, 8'h33, 4'h1, 8'h44);
        rst_n[1] = 1'b0;
        #1;
        check_reset_vals(1);
        m_err[1] = 8'h00;
        @(negedge clk);
        rst_n[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("no_rsp_after_reset", rsp_valid[1], 1'b0);
            @(negedge clk);
        end
        do_txn(1, 8'h33, 4'h1, 8'h44, ref_exp(8'h33, 4'h1, 8'h44), 0, 1'b0);

        // Randomized transactions on both instances
        for (int n = 0; n < 190; n++) begin
            int d;
            d  = (n < 150) ? 0 : 1;
            ra = 8'($urandom);
            rb = 4'($urandom);
            rc = 8'($urandom);
            e  = ref_exp(ra, rb, rc);
            xv = ($urandom_range(0, 2) == 0) ? (e ^ 8'($urandom_range(1, 255))) : e;
            do_txn(d, ra, rb, rc, xv, int'($urandom_range(0, 3)),
                   ($urandom_range(0, 15) == 0));
        end

        // Saturation of the error counter
        for (int n = 0; n < 260; n++) begin
            ra = 8'($urandom);
            rb = 4'($urandom);
            rc = 8'($urandom);
            do_txn(0, ra, rb, rc, ref_exp(ra, rb, rc) ^ 8'h80, 0, 1'b0);
        end
        chk("err_saturated", err_count[0], 8'd255);

        // Standalone clear
        err_clr[0] = 1'b1;
        @(negedge clk);
        err_clr[0] = 1'b0;
        m_err[0] = 8'h00;
        chk("err_cleared", err_count[0], 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
